sample_capture: RTL
===================

# sample_capture

Small logic-analyser capture engine that consumes the 20-bit sample vector exported by the blink counter stage and records a window of it around a trigger. Sits directly downstream of the DUT in the clk0 domain (PLL CLK0 output). Stores PRE_TRIG samples before and DEPTH-PRE_TRIG-1 samples after the trigger sample in a circular buffer. Streams the window out oldest-first over a valid/ready port.

## Interface
- WIDTH, 20, sample width in bits.
- DEPTH, 16, buffer depth in samples; power of two, at least 4.
- PRE_TRIG, 4, samples kept before the trigger sample; legal range 0..DEPTH-1.

- clk0  in  1  capture clock (PLL CLK0, 40 MHz).
- rst  in  1  reset; synchronous, active-low.
- sample_in  in  WIDTH  DUT sample, sampled every clk0 edge.
- trig_value  in  WIDTH  trigger compare value; static while armed.
- trig_mask  in  WIDTH  1 = bit participates in compare; static while armed.
- arm  in  1  start request; honoured only in IDLE.
- busy  out  1  high in PRE, WAIT_TRIG, POST and READOUT.
- triggered  out  1  high from the cycle after the trigger match until the next arm.
- done  out  1  high in IDLE after a completed readout; cleared by arm.
- rd_data  out  WIDTH  readout word.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  consumer accepts word.
- rd_last  out  1  marks the final (DEPTH-th) word; only meaningful with rd_valid.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, READOUT.
- IDLE: no writes. If arm is high, go to PRE, or to WAIT_TRIG when PRE_TRIG=0. Clear done, triggered, wr_ptr and counters.
- PRE: write sample_in to mem[wr_ptr] every cycle and increment wr_ptr. After PRE_TRIG writes, go to WAIT_TRIG. Trigger matches in PRE are ignored.
- WAIT_TRIG: write every cycle and increment wr_ptr, wrapping modulo DEPTH.
  - Match condition: ((sample_in ^ trig_value) & trig_mask) == 0.
  - On a match, write the sample, latch trig_addr = wr_ptr and set triggered.
  - Go to POST, or straight to READOUT when PRE_TRIG = DEPTH-1.
  - A mask of all zeros matches on the first WAIT_TRIG cycle.
- POST: write exactly DEPTH-PRE_TRIG-1 further samples, then go to READOUT.
- READOUT: rd_ptr starts at (trig_addr - PRE_TRIG) mod DEPTH. rd_data = mem[rd_ptr].
  - Each rd_valid && rd_ready advances rd_ptr modulo DEPTH and increments the word counter.
  - rd_last is high on word DEPTH-1.
  - When the last word is accepted, go to IDLE and set done.
- The trigger sample is always word index PRE_TRIG of the readout.
- arm outside IDLE is ignored, including arm during READOUT.
- Reset mid-operation: next cycle is IDLE. Buffer contents are don't-care.
- Reset values: busy=0, triggered=0, done=0, rd_valid=0, rd_last=0, rd_data=0.

## Timing
- Arm sampled high at edge N: state changes at N. The first sample write occurs at edge N+1.
- PRE writes occur at edges N+1..N+PRE_TRIG.
- Trigger matched at edge T: POST writes occur at edges T+1..T+DEPTH-PRE_TRIG-1. READOUT is entered on the edge of the last POST write.
- rd_valid is high the cycle after the last write. Read latency is zero: rd_data comes from a combinational mux over the register array.
- Throughput is one word per cycle with rd_ready held high. The DEPTH words occupy DEPTH consecutive cycles.
- With rd_valid high and rd_ready low, rd_data and rd_last hold stable. rd_valid never drops before acceptance.
- done asserts on the edge that accepts the last word. busy deasserts on that same edge.

## Structure
- Package sample_capture_pkg holds the state enum cap_state_t (IDLE, PRE, WAIT_TRIG, POST, READOUT).
- The package also holds a helper function for the address width, $clog2(DEPTH).
- Sub-module capture_ram: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
- Top level holds the FSM, wr_ptr/rd_ptr (ADDR_W bits, natural wrap), a post/pre counter and a readout word counter.

## Test plan
- Counter source, DEPTH=16, PRE_TRIG=4, trig_value=0x00100, mask=0xFFFFF, rd_ready=1 -> 16 words 0x000FC..0x0010B; word 4 = 0x00100; rd_last with 0x0010B; done is set.
- Mask=0x00000, PRE_TRIG=4, arm when the counter is at 0x00010 -> match on the first WAIT_TRIG cycle; readout 0x00011..0x00020; word 4 = 0x00015.
- PRE_TRIG=0, then PRE_TRIG=15, trigger 0x00100 -> first word 0x00100 and 0x000F1 respectively; trigger at index 0 and 15; no POST state with PRE_TRIG=15.
- Back-pressure: toggle rd_ready every other cycle during readout -> rd_data/rd_last held while stalled; same 16 words in order; readout takes 32 cycles.
- Wrap-around: trigger at counter 0x00040 after more than 2*DEPTH WAIT_TRIG cycles -> correct window 0x0003C..0x0004B despite wrapping wr_ptr.
- Reset and arm robustness:
  - rst low for one cycle during POST -> next cycle IDLE with busy=0, triggered=0, rd_valid=0; a re-arm captures correctly.
  - arm pulsed during READOUT -> ignored.

Source files
------------

// File: rtl/sample_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture_pkg
// Description : Shared types and helpers for the sample_capture engine.
//               cap_state_t : capture FSM state encoding.
//               addr_width(): buffer address width for a given depth.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READOUT   = 3'd4
  } cap_state_t;

  // Address width of the circular buffer; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram
// Description : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous (combinational) read port.
// Ports       : clk0     - write clock
//               wr_en    - write enable
//               wr_addr  - write address
//               wr_data  - write data
//               rd_addr  - read address
//               rd_data  - read data (zero latency)
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ram #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk0,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are not reset: the capture window is always fully rewritten
  // before it is read out.
  always_ff @(posedge clk0) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture
// Description : Logic-analyser capture engine. Records PRE_TRIG samples
//               before and DEPTH-PRE_TRIG-1 samples after a masked trigger
//               match into a circular buffer, then streams the window out
//               oldest-first over a valid/ready port.
// Ports       : clk0        - capture clock
//               rst         - synchronous active-low reset
//               sample_in   - sample vector, captured every edge
//               trig_value  - trigger compare value
//               trig_mask   - 1 = bit participates in compare
//               arm         - start request (IDLE only)
//               busy        - capture or readout in progress
//               triggered   - trigger seen since last arm
//               done        - readout completed
//               rd_data     - readout word
//               rd_valid    - readout word valid
//               rd_ready    - consumer accepts word
//               rd_last     - final word of the window
// Revision    : 1.0 - initial release
// ============================================================================
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic             arm,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last
);

  localparam int c_addr_w = addr_width(DEPTH);

  // Terminal counts. The PRE and POST ones wrap to all-ones when the
  // corresponding phase is empty; in that case the phase is never entered.
  localparam logic [c_addr_w-1:0] c_pre         = c_addr_w'(PRE_TRIG);
  localparam logic [c_addr_w-1:0] c_pre_last    = c_addr_w'(PRE_TRIG - 1);
  localparam logic [c_addr_w-1:0] c_post_last   = c_addr_w'(DEPTH - PRE_TRIG - 2);
  localparam logic [c_addr_w-1:0] c_word_penult = c_addr_w'(DEPTH - 2);

  cap_state_t          r_state;
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w-1:0] r_trig_addr;
  logic [c_addr_w-1:0] r_cnt;
  logic [c_addr_w-1:0] r_word_cnt;
  logic                r_busy;
  logic                r_triggered;
  logic                r_done;
  logic                r_rd_valid;
  logic                r_rd_last;

  logic                w_match;
  logic                w_wr_en;
  logic [WIDTH-1:0]    w_ram_rd;

  assign w_match = (((sample_in ^ trig_value) & trig_mask) == '0);
  assign w_wr_en = (r_state == PRE) || (r_state == WAIT_TRIG) || (r_state == POST);

  capture_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (c_addr_w)
  ) u_ram (
    .clk0    (clk0),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (sample_in),
    .rd_addr (r_rd_ptr),
    .rd_data (w_ram_rd)
  );

  always_ff @(posedge clk0) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_word_cnt  <= '0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state     <= (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_triggered <= 1'b0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_word_cnt  <= '0;
          end
        end

        PRE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_pre_last) begin
            r_state <= WAIT_TRIG;
            r_cnt   <= '0;
          end
        end

        WAIT_TRIG: begin
          if (w_match) begin
            r_trig_addr <= r_wr_ptr;
            r_triggered <= 1'b1;
            r_cnt       <= '0;
            if (PRE_TRIG == DEPTH - 1) begin
              // Trigger sample is the last word of the window.
              r_state    <= READOUT;
              r_rd_ptr   <= r_wr_ptr - c_pre;
              r_rd_valid <= 1'b1;
            end else begin
              r_state <= POST;
            end
          end
        end

        POST: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_post_last) begin
            r_state    <= READOUT;
            r_rd_ptr   <= r_trig_addr - c_pre;
            r_rd_valid <= 1'b1;
            r_cnt      <= '0;
          end
        end

        READOUT: begin
          if (r_rd_valid && rd_ready) begin
            if (r_rd_last) begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end else begin
              r_rd_ptr   <= r_rd_ptr + 1'b1;
              r_word_cnt <= r_word_cnt + 1'b1;
              // Flag goes up together with the pointer step onto the
              // final word, so it is aligned with that word's data.
              r_rd_last  <= (r_word_cnt == c_word_penult);
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign done      = r_done;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  // Gate the array read so the port shows zero outside a readout.
  assign rd_data   = r_rd_valid ? w_ram_rd : '0;

endmodule
`default_nettype wire
